// File: rtl/vline_counter_if.sv
// Bus bundle between the video timing/CPU side and the vertical line counter.
// Scalar clock and reset are kept outside the bundle on purpose.
interface vline_counter_if;
    logic       HEND;
    logic       PAL;
    logic       WR;
    logic [1:0] ADDR;
    logic [8:0] DIN;
    logic       INTACK;
    logic [8:0] VCNT;
    logic       FRAME;
    logic       VBLANK;
    logic       VSYNC;
    logic       VINT;

    modport master (
        output HEND, PAL, WR, ADDR, DIN, INTACK,
        input  VCNT, FRAME, VBLANK, VSYNC, VINT
    );

    modport slave (
        input  HEND, PAL, WR, ADDR, DIN, INTACK,
        output VCNT, FRAME, VBLANK, VSYNC, VINT
    );
endinterface

// File: rtl/vline_counter.sv
// Vertical line counter: wraps at the PAL/NTSC frame length and derives
// VBLANK, fixed-width VSYNC and a sticky line interrupt from programmable lines.
module vline_counter #(
    parameter int LAST_PAL  = 311,
    parameter int LAST_NTSC = 261,
    parameter int VS_LINES  = 3
) (
    input  logic            MasterClock,
    input  logic            RESETL,
    vline_counter_if.slave  bus
);

    localparam logic [8:0] LAST_PAL_W  = 9'(LAST_PAL);
    localparam logic [8:0] LAST_NTSC_W = 9'(LAST_NTSC);
    localparam logic [8:0] VS_LOAD     = 9'(VS_LINES - 1);

    logic [8:0] vcnt_q,    vcnt_d;
    logic       frame_q,   frame_d;
    logic       cmp_q,     cmp_d;
    logic       vblank_q,  vblank_d;
    logic       vsync_q,   vsync_d;
    logic [8:0] vs_cnt_q,  vs_cnt_d;
    logic       vint_q,    vint_d;
    logic [8:0] intline_q, intline_d;
    logic [8:0] vbstart_q, vbstart_d;
    logic [8:0] vbend_q,   vbend_d;
    logic [8:0] vsstart_q, vsstart_d;

    logic [8:0] last;
    logic       hit_int;
    logic       hit_vbstart;
    logic       hit_vbend;
    logic       hit_vsstart;

    always_comb begin
        last = bus.PAL ? LAST_PAL_W : LAST_NTSC_W;

        vcnt_d    = vcnt_q;
        frame_d   = 1'b0;
        cmp_d     = bus.HEND;
        vblank_d  = vblank_q;
        vsync_d   = vsync_q;
        vs_cnt_d  = vs_cnt_q;
        vint_d    = vint_q;
        intline_d = intline_q;
        vbstart_d = vbstart_q;
        vbend_d   = vbend_q;
        vsstart_d = vsstart_q;

        // The >= compare forces a wrap when switching to the shorter frame mid-frame.
        if (bus.HEND) begin
            if (vcnt_q >= last) begin
                vcnt_d  = 9'd0;
                frame_d = 1'b1;
            end else begin
                vcnt_d = vcnt_q + 9'd1;
            end
        end

        // A register programmed beyond the current final line is inert.
        hit_int     = (vcnt_q == intline_q) && (intline_q <= last);
        hit_vbstart = (vcnt_q == vbstart_q) && (vbstart_q <= last);
        hit_vbend   = (vcnt_q == vbend_q)   && (vbend_q   <= last);
        hit_vsstart = (vcnt_q == vsstart_q) && (vsstart_q <= last);

        if (cmp_q) begin
            if (hit_vbend) begin
                vblank_d = 1'b0;
            end else if (hit_vbstart) begin
                vblank_d = 1'b1;
            end

            if (hit_vsstart) begin
                vsync_d  = 1'b1;
                vs_cnt_d = VS_LOAD;
            end else if (vsync_q) begin
                if (vs_cnt_q == 9'd0) begin
                    vsync_d = 1'b0;
                end else begin
                    vs_cnt_d = vs_cnt_q - 9'd1;
                end
            end
        end

        if (cmp_q && hit_int) begin
            vint_d = 1'b1;
        end else if (bus.INTACK) begin
            vint_d = 1'b0;
        end

        // Compares above read the _q registers, so a write colliding with a strobe sees the old value.
        if (bus.WR) begin
            case (bus.ADDR)
                2'd0: intline_d = bus.DIN;
                2'd1: vbstart_d = bus.DIN;
                2'd2: vbend_d   = bus.DIN;
                2'd3: vsstart_d = bus.DIN;
            endcase
        end
    end

    always_ff @(posedge MasterClock) begin
        if (!RESETL) begin
            vcnt_q    <= 9'd0;
            frame_q   <= 1'b0;
            cmp_q     <= 1'b0;
            vblank_q  <= 1'b0;
            vsync_q   <= 1'b0;
            vs_cnt_q  <= 9'd0;
            vint_q    <= 1'b0;
            intline_q <= 9'd511;
            vbstart_q <= 9'd240;
            vbend_q   <= 9'd0;
            vsstart_q <= 9'd248;
        end else begin
            vcnt_q    <= vcnt_d;
            frame_q   <= frame_d;
            cmp_q     <= cmp_d;
            vblank_q  <= vblank_d;
            vsync_q   <= vsync_d;
            vs_cnt_q  <= vs_cnt_d;
            vint_q    <= vint_d;
            intline_q <= intline_d;
            vbstart_q <= vbstart_d;
            vbend_q   <= vbend_d;
            vsstart_q <= vsstart_d;
        end
    end

    assign bus.VCNT   = vcnt_q;
    assign bus.FRAME  = frame_q;
    assign bus.VBLANK = vblank_q;
    assign bus.VSYNC  = vsync_q;
    assign bus.VINT   = vint_q;

endmodule

// File: doc/vline_counter.md
# vline_counter

Vertical line counter and timing-flag generator for the Slipstream video path. It counts scan lines on each end-of-line pulse from the horizontal counter and wraps at the PAL or NTSC frame length. Its 9-bit count drives the downstream 9-bit equality comparators. It also performs its own registered compares against four CPU-programmable line registers to produce VBLANK, a fixed-width VSYNC, and a sticky line interrupt.

## Interface
- LAST_PAL, default 311: final line index in PAL mode (312 lines).
- LAST_NTSC, default 261: final line index in NTSC mode (262 lines).
- VS_LINES, default 3: VSYNC width in lines.

- MasterClock  in  1  sole clock; all state changes on rising edge.
- RESETL  in  1  synchronous active-low reset; sampled on MasterClock.
- HEND  in  1  one-cycle pulse marking end of a scan line.
- PAL  in  1  1 = PAL frame length, 0 = NTSC.
- WR  in  1  register write strobe, one cycle.
- ADDR  in  2  register select: 0 INTLINE, 1 VBSTART, 2 VBEND, 3 VSSTART.
- DIN  in  9  register write data.
- INTACK  in  1  clears VINT.
- VCNT  out  9  current line number.
- FRAME  out  1  one-cycle pulse on wrap to line 0.
- VBLANK  out  1  vertical blank.
- VSYNC  out  1  vertical sync.
- VINT  out  1  line-interrupt request, sticky.

## Operation
- Reset (RESETL=0 at an edge) sets the following, with reset dominating every other input:
  - VCNT=0, FRAME=0, VBLANK=0, VSYNC=0, VINT=0, VSYNC line counter=0.
  - INTLINE=511, VBSTART=240, VBEND=0, VSSTART=248.
- Counter:
  - Edge with HEND=1: if VCNT >= LAST (LAST_PAL when PAL=1, else LAST_NTSC), VCNT <- 0 and FRAME=1 for that cycle.
  - Otherwise VCNT <- VCNT+1.
  - The >= test guarantees a wrap after a PAL-to-NTSC switch mid-frame. VCNT never exceeds 311.
- Compare strobe: internal CMP = HEND delayed one clock. All flag updates occur only on edges where CMP=1, using the already-updated VCNT.
- VBLANK:
  - Set when VCNT==VBSTART; cleared when VCNT==VBEND.
  - If both match on the same strobe, clear wins.
- VSYNC:
  - Asserted when VCNT==VSSTART; the line counter loads VS_LINES-1.
  - On each later strobe the counter decrements. VSYNC deasserts on the strobe where the counter is 0.
  - The result is VSYNC high for exactly VS_LINES lines.
  - A VSSTART match while VSYNC is already high restarts the count.
- VINT:
  - Set on strobe when VCNT==INTLINE; cleared on any edge with INTACK=1.
  - Simultaneous set and INTACK: set wins.
- Register writes: on WR=1 edge, register[ADDR] <- DIN. The new value is used by the next strobe. A write in the same cycle as CMP compares against the old value.
- A register value above the current LAST never matches, so its flag never changes from that register.
- HEND pulses closer than 2 clocks apart are illegal and need not be handled.

## Timing
- VCNT latency: 1 clock after the HEND edge.
- FRAME: asserted in the same cycle VCNT becomes 0.
- Flag latency: VBLANK, VSYNC and VINT change 2 clocks after the HEND edge, i.e. 1 clock after VCNT.
- All outputs are registered. There is no combinational path from any input to any output.
- Reset mid-frame: the next edge with RESETL=1 and HEND=1 yields VCNT=1. The CMP pipeline bit is also cleared by reset.

## Test plan
- Reset, PAL=1, 312 HEND pulses every 4 clocks:
  - VCNT runs 0..311 and then 0.
  - FRAME pulses exactly once, with VCNT=0.
- NTSC wrap: PAL=0 → wrap 261→0. Switch PAL 1→0 while VCNT=300 → next HEND gives VCNT=0 plus FRAME.
- Write VBSTART=10, VBEND=20:
  - VBLANK rises 1 clock after VCNT becomes 10.
  - VBLANK falls 1 clock after VCNT becomes 20.
  - With VBSTART=VBEND=15, VBLANK stays 0.
- Write VSSTART=5: VSYNC is high during lines 5, 6, 7 and low from the strobe for line 8.
- Write INTLINE=100:
  - VINT sets at line 100 and holds until INTACK.
  - INTACK on the same edge as the line-100 strobe leaves VINT=1.
  - INTLINE=400 in NTSC never sets VINT.
- Mid-frame reset at VCNT=150 with VBLANK/VSYNC/VINT high: all outputs return to 0 and registers return to their defaults.
